// File: rtl/mon_mem_engine.sv
// mon_mem_engine: executes one monitor command at a time (WRITE, DUMP, FILL).
// Each word goes to main memory or to the rf/csr/io register space, decoded
// from the top two address bits. Dump words go to the UART sender over a
// valid/ready handshake.
// Optional build macro FILL_INC_EN: FILL writes pattern + n to the n-th word.
module mon_mem_engine #(
   parameter int ADR_W   = 32,
   parameter int DATA_W  = 32,
   parameter int REG_AW  = 14,
   parameter int REG_LAT = 1,
   parameter int TO_W    = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ADR_W-1:0]  cmd_start_adr,
   input  logic [ADR_W-1:0]  cmd_end_adr,
   input  logic [DATA_W-1:0] cmd_wdata,
   input  logic              abort,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADR_W-1:0]  mem_adr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [1:0]        reg_sel,
   output logic              reg_re,
   output logic              reg_we,
   output logic [REG_AW-1:0] reg_adr,
   output logic [DATA_W-1:0] reg_wdata,
   input  logic [DATA_W-1:0] reg_rdata,
   output logic              snd_valid,
   output logic [DATA_W-1:0] snd_data,
   input  logic              snd_ready,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_FILL  = 2'b10;
   localparam logic [1:0] OP_RSVD  = 2'b11;
   localparam logic [1:0] SP_MEM   = 2'b01;
   // The counter times out on the cycle it would reach all-ones.
   localparam logic [TO_W-1:0] TO_LAST  = {{(TO_W-1){1'b1}}, 1'b0};
   localparam logic [2:0]      LAT_LAST = 3'(REG_LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_MWAIT, S_RWAIT, S_SEND, S_NEXT, S_FIN
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [1:0]         r_op;
   logic [ADR_W-1:0]   r_cur_adr;
   logic [ADR_W-3:0]   r_end_w;
   logic [DATA_W-1:0]  r_wdata;
   logic [DATA_W-1:0]  r_rdata;
   logic [TO_W-1:0]    r_to_cnt;
   logic [2:0]         r_lat_cnt;
   logic               r_abort;
   logic               r_err;

   logic w_accept, w_is_mem, w_is_wr, w_abort_any, w_last;
   logic w_to_hit, w_lat_hit, w_timeout, w_adv;
   logic w_unused;

   assign w_accept    = (r_state == S_IDLE) && cmd_valid;
   assign w_is_mem    = (r_cur_adr[ADR_W-1:ADR_W-2] == SP_MEM);
   assign w_is_wr     = (r_op == OP_WRITE) || (r_op == OP_FILL);
   assign w_abort_any = abort || r_abort;
   // Stop at the end address, and never wrap past the top of the address map.
   assign w_last      = (r_cur_adr[ADR_W-1:2] >= r_end_w) || (&r_cur_adr[ADR_W-1:2]);
   assign w_to_hit    = (r_to_cnt == TO_LAST);
   assign w_lat_hit   = (r_lat_cnt == LAT_LAST);
   assign w_timeout   = (r_state == S_MWAIT) && !mem_ack && w_to_hit;
   // Byte-lane bits of the command addresses are deliberately ignored.
   assign w_unused    = ^{cmd_start_adr[1:0], cmd_end_adr[1:0]};

   assign cmd_ready = (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);
   assign mem_adr   = r_cur_adr;
   assign mem_wdata = r_wdata;
   assign reg_sel   = r_cur_adr[ADR_W-1:ADR_W-2];
   assign reg_adr   = r_cur_adr[REG_AW+1:2];
   assign reg_wdata = r_wdata;
   assign snd_data  = r_rdata;
   assign err       = r_err;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next-state and strobe decode. SEND folds in the address step so a
   // register dump sustains one word every three cycles.
   always_comb begin
      w_next    = r_state;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      reg_re    = 1'b0;
      reg_we    = 1'b0;
      snd_valid = 1'b0;
      done      = 1'b0;
      w_adv     = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (cmd_valid) w_next = (cmd_op == OP_RSVD) ? S_FIN : S_ISSUE;
         end
         S_ISSUE: begin
            if (abort) begin
               w_next = S_FIN;
            end else if (w_is_mem) begin
               w_next = S_MWAIT;
            end else if (w_is_wr) begin
               reg_we = 1'b1;
               w_next = (r_op == OP_WRITE) ? S_FIN : S_NEXT;
            end else begin
               reg_re = 1'b1;
               w_next = S_RWAIT;
            end
         end
         S_MWAIT: begin
            mem_req = 1'b1;
            mem_we  = w_is_wr;
            if (mem_ack) begin
               if (w_abort_any || (r_op == OP_WRITE)) w_next = S_FIN;
               else if (w_is_wr)                      w_next = S_NEXT;
               else                                   w_next = S_SEND;
            end else if (w_to_hit) begin
               w_next = S_FIN;
            end
         end
         S_RWAIT: begin
            if (w_lat_hit) w_next = w_abort_any ? S_FIN : S_SEND;
         end
         S_SEND: begin
            if (abort) begin
               w_next = S_FIN;
            end else begin
               snd_valid = 1'b1;
               if (snd_ready) begin
                  if (w_last) begin
                     w_next = S_FIN;
                  end else begin
                     w_adv  = 1'b1;
                     w_next = S_ISSUE;
                  end
               end
            end
         end
         S_NEXT: begin
            if (abort || w_last || (r_op == OP_WRITE)) begin
               w_next = S_FIN;
            end else begin
               w_adv  = 1'b1;
               w_next = S_ISSUE;
            end
         end
         S_FIN: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Command latch, address walk, wait counters, captured read data, flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_op      <= '0;
         r_cur_adr <= '0;
         r_end_w   <= '0;
         r_wdata   <= '0;
         r_rdata   <= '0;
         r_to_cnt  <= '0;
         r_lat_cnt <= '0;
         r_abort   <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         if (w_accept) begin
            r_op      <= cmd_op;
            r_cur_adr <= {cmd_start_adr[ADR_W-1:2], 2'b00};
            r_end_w   <= cmd_end_adr[ADR_W-1:2];
            r_wdata   <= cmd_wdata;
            r_err     <= 1'b0;
            r_abort   <= 1'b0;
         end else if (w_adv) begin
            r_cur_adr <= r_cur_adr + ADR_W'(4);
`ifdef FILL_INC_EN
            if (r_op == OP_FILL) r_wdata <= r_wdata + DATA_W'(1);
`endif
         end
         if (r_state == S_MWAIT) r_to_cnt <= r_to_cnt + TO_W'(1);
         else                    r_to_cnt <= '0;
         if (r_state == S_RWAIT) r_lat_cnt <= r_lat_cnt + 3'd1;
         else                    r_lat_cnt <= '0;
         // An abort during a bus wait is held until the transfer completes.
         if (((r_state == S_MWAIT) || (r_state == S_RWAIT)) && abort) r_abort <= 1'b1;
         if ((r_state == S_MWAIT) && mem_ack && !w_is_wr) r_rdata <= mem_rdata;
         if ((r_state == S_RWAIT) && w_lat_hit)           r_rdata <= reg_rdata;
         if (w_timeout) r_err <= 1'b1;
      end
   end

endmodule
